// File: rtl/simplez_bus_if.sv
// Simplez CPU peripheral bus: address, read/write strobes and the two data buses.
interface simplez_bus_if;
  logic [8:0]  addr;
  logic        wr;
  logic        rd;
  logic [11:0] data_in;
  logic [11:0] data_out;

  modport master (output addr, wr, rd, data_in, input  data_out);
  modport slave  (input  addr, wr, rd, data_in, output data_out);
endinterface

// File: rtl/simplez_tx_port.sv
// Simplez UART transmit port: 1-entry holding register feeding an 8N1 shifter,
// with a status register (OVR/BUSY/READY). All state moves on the falling clock edge.
module simplez_tx_port #(
  parameter int       DIVISOR   = 104,
  parameter bit [8:0] ADDR_DATA = 9'o101,
  parameter bit [8:0] ADDR_STAT = 9'o102
) (
  input  logic            clk,
  input  logic            rstn,
  simplez_bus_if.slave    bus,
  output logic            tx
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [11:0] BAUD_MAX = 12'(DIVISOR - 1);

  state_t      state_q, state_d;
  logic [9:0]  shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  logic        ovr_q, ovr_d;
  logic        tx_q, tx_d;
  logic        load;
  logic        wr_data, rd_stat;

  assign wr_data = bus.wr && (bus.addr == ADDR_DATA);
  assign rd_stat = bus.rd && (bus.addr == ADDR_STAT);

  assign bus.data_out = (bus.addr == ADDR_STAT)
                      ? {9'b0, ovr_q, (state_q == SHIFT), ~full_q}
                      : 12'b0;
  assign tx = tx_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    hold_d     = hold_q;
    full_d     = full_q;
    ovr_d      = ovr_q;
    load       = 1'b0;

    case (state_q)
      IDLE: if (full_q) load = 1'b1;
      SHIFT: begin
        if (baud_cnt_q == BAUD_MAX) begin
          baud_cnt_d = 12'd0;
          if (bit_cnt_q == 4'd9) begin
            // End of stop bit: chain straight into the next frame if one is waiting.
            if (full_q) load = 1'b1;
            else        state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shreg_d   = {1'b1, shreg_q[9:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d    = {1'b1, hold_q, 1'b0};
      bit_cnt_d  = 4'd0;
      baud_cnt_d = 12'd0;
      state_d    = SHIFT;
      full_d     = 1'b0;
    end

    if (rd_stat) ovr_d = 1'b0;
    // A write landing on the transfer edge sees HOLD as free.
    if (wr_data) begin
      if (!full_q || load) begin
        hold_d = bus.data_in[7:0];
        full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    tx_d = (state_d == SHIFT) ? shreg_d[0] : 1'b1;
  end

  always_ff @(negedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shreg_q    <= 10'h3ff;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= 12'd0;
      hold_q     <= 8'd0;
      full_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      ovr_q      <= ovr_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_simplez_tx_port.sv
// Directed bench for simplez_tx_port at DIVISOR=4: reset, framing, back-to-back,
// overrun, mid-frame reset and address decode.
module tb_simplez_tx_port;

  localparam logic [8:0] ADDR_DATA = 9'o101;
  localparam logic [8:0] ADDR_STAT = 9'o102;
  localparam logic [8:0] ADDR_NONE = 9'o100;

  logic clk;
  logic rstn;
  logic tx;
  int   n_chk  = 0;
  int   n_fail = 0;

  simplez_bus_if bus ();

  simplez_tx_port #(.DIVISOR(4), .ADDR_DATA(ADDR_DATA), .ADDR_STAT(ADDR_STAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave),
    .tx   (tx)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge,
  // half a period away from the active falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the load edge; checks 40 cycles of line and BUSY, optionally
  // writing a second byte mid-frame.
  task automatic check_frame(input logic [7:0] b, input bit do_wr, input logic [11:0] wdata);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) begin
      chk("frame_tx", {11'b0, tx}, {11'b0, f[i/4]});
      chk("frame_busy", {11'b0, bus.data_out[1]}, 12'd1);
      if (do_wr && i == 5) begin
        bus.wr = 1'b1; bus.addr = ADDR_DATA; bus.data_in = wdata;
      end
      cyc();
      bus.wr = 1'b0; bus.addr = ADDR_STAT;
      #1;
    end
  endtask

  initial begin
    logic [9:0] f;
    int n;
    bus.addr = ADDR_STAT; bus.wr = 1'b0; bus.rd = 1'b0; bus.data_in = 12'd0;
    rstn = 1'b0;
    cyc(); cyc(); cyc();
    rstn = 1'b1;

    // Reset state
    chk("rst_status", bus.data_out, 12'o0001);
    chk("rst_tx", {11'b0, tx}, 12'd1);
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("idle_tx", {11'b0, tx}, 12'd1);
    end

    // Single frame 0xA5
    bus.wr = 1'b1; bus.addr = ADDR_DATA; bus.data_in = 12'h0A5;
    cyc();
    bus.wr = 1'b0; bus.addr = ADDR_STAT; #1;
    chk("a5_held_status", bus.data_out, 12'o0000);
    cyc();
    chk("a5_start_status", bus.data_out, 12'o0003);
    check_frame(8'hA5, 1'b0, 12'd0);
    chk("a5_end_status", bus.data_out, 12'o0001);
    chk("a5_end_tx", {11'b0, tx}, 12'd1);

    // Back-to-back: 0x55 (upper data bits ignored) then 0x0F written mid-frame
    bus.wr = 1'b1; bus.addr = ADDR_DATA; bus.data_in = 12'hF55;
    cyc();
    bus.wr = 1'b0; bus.addr = ADDR_STAT; #1;
    cyc();
    check_frame(8'h55, 1'b1, 12'h00F);
    check_frame(8'h0F, 1'b0, 12'd0);
    chk("b2b_end_status", bus.data_out, 12'o0001);
    chk("b2b_end_tx", {11'b0, tx}, 12'd1);

    // Three consecutive writes: second lands on the transfer edge, third overruns
    bus.wr = 1'b1; bus.addr = ADDR_DATA; bus.data_in = 12'h011;
    cyc();
    bus.data_in = 12'h022;
    cyc();
    bus.data_in = 12'h033;
    cyc();
    bus.wr = 1'b0; bus.addr = ADDR_STAT; #1;
    chk("ovr_status", bus.data_out, 12'o0006);
    bus.rd = 1'b1;
    cyc();
    bus.rd = 1'b0; #1;
    chk("ovr_clr_status", bus.data_out, 12'o0002);
    n = 0;
    while (bus.data_out !== 12'o0001 && n < 300) begin
      cyc();
      n++;
    end
    chk("ovr_drain_status", bus.data_out, 12'o0001);
    chk("ovr_drain_len", 12'(n), 12'd78);

    // Mid-frame reset during the third bit, with a byte pending in HOLD
    bus.wr = 1'b1; bus.addr = ADDR_DATA; bus.data_in = 12'h0FF;
    cyc();
    bus.wr = 1'b0; bus.addr = ADDR_STAT; #1;
    cyc();
    f = {1'b1, 8'hFF, 1'b0};
    for (int i = 0; i < 9; i++) begin
      chk("rst_frame_tx", {11'b0, tx}, {11'b0, f[i/4]});
      if (i == 5) begin
        bus.wr = 1'b1; bus.addr = ADDR_DATA; bus.data_in = 12'h03C;
      end
      cyc();
      bus.wr = 1'b0; bus.addr = ADDR_STAT; #1;
    end
    chk("pre_rst_status", bus.data_out, 12'o0002);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1; #1;
    chk("midrst_tx", {11'b0, tx}, 12'd1);
    chk("midrst_status", bus.data_out, 12'o0001);
    for (int i = 0; i < 60; i++) begin
      cyc();
      chk("postrst_tx", {11'b0, tx}, 12'd1);
    end
    chk("postrst_status", bus.data_out, 12'o0001);

    // Address decode: reads of DATA/unmapped are zero, writes elsewhere do nothing
    bus.addr = ADDR_DATA; #1;
    chk("rd_data_addr", bus.data_out, 12'o0000);
    bus.addr = ADDR_NONE; #1;
    chk("rd_none_addr", bus.data_out, 12'o0000);
    bus.wr = 1'b1; bus.data_in = 12'h05A;
    cyc();
    bus.addr = ADDR_STAT; bus.data_in = 12'h0A5;
    cyc();
    bus.wr = 1'b0; #1;
    chk("badwr_status", bus.data_out, 12'o0001);
    for (int i = 0; i < 30; i++) begin
      cyc();
      chk("badwr_tx", {11'b0, tx}, 12'd1);
    end
    chk("badwr_end_status", bus.data_out, 12'o0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
